// File: rtl/ov7670_emitter.sv
// OV7670-style pixel bus transmitter: replays an RGB444 frame buffer as "xR GB" byte pairs
// with vsync/href framing and programmable blanking.
module ov7670_emitter #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    output logic [18:0] fb_addr,
    output logic        fb_rd,
    input  logic [11:0] fb_data,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        busy,
    output logic        frame_done
);
    localparam int LP  = 2*H_ACTIVE + H_BLANK;
    localparam int FL  = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HCW = $clog2(LP);
    localparam int VCW = $clog2(FL);

    localparam logic [HCW-1:0] HC_LAST   = HCW'(LP - 1);
    localparam logic [HCW-1:0] HC_PRE    = HCW'(LP - 2);
    localparam logic [HCW-1:0] HC_ACT    = HCW'(2*H_ACTIVE);
    localparam logic [HCW-1:0] HC_RD_LIM = HCW'(2*H_ACTIVE - 2);
    localparam logic [VCW-1:0] VC_SYNC_END = VCW'(VSYNC_LINES - 1);
    localparam logic [VCW-1:0] VC_BACK_END = VCW'(VSYNC_LINES + V_BACK - 1);
    localparam logic [VCW-1:0] VC_ACT_END  = VCW'(VSYNC_LINES + V_BACK + V_ACTIVE - 1);
    localparam logic [VCW-1:0] VC_LAST     = VCW'(FL - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

    state_t         state_q, state_d;
    logic [HCW-1:0] hc_q, hc_d;
    logic [VCW-1:0] vc_q, vc_d;
    logic [18:0]    fb_addr_q, fb_addr_d;
    logic           fb_rd_q, fb_rd_d;
    logic           vsync_q, vsync_d;
    logic           href_q, href_d;
    logic [7:0]     d_q, d_d;
    logic [7:0]     gb_q, gb_d;
    logic           busy_q, busy_d;
    logic           pend_q, pend_d;
    logic           frame_done_q, frame_done_d;
    logic           line_end, in_act, next_line_act;

    // Counters describe the cycle the output registers will present after the next edge.
    always_comb begin
        state_d   = state_q;
        hc_d      = hc_q;
        vc_d      = vc_q;
        fb_addr_d = fb_addr_q + 19'(fb_rd_q);
        pend_d    = 1'b0;
        line_end  = (hc_q == HC_LAST);
        if (state_q == S_IDLE) begin
            hc_d = '0;
            vc_d = '0;
            if (en) state_d = S_VSYNC;
        end else begin
            hc_d = line_end ? '0 : hc_q + HCW'(1);
            if (line_end) begin
                vc_d = vc_q + VCW'(1);
                case (state_q)
                    S_VSYNC:  if (vc_q == VC_SYNC_END) state_d = S_VBACK;
                    S_VBACK:  if (vc_q == VC_BACK_END) state_d = S_ACTIVE;
                    S_ACTIVE: if (vc_q == VC_ACT_END)  state_d = S_VFRONT;
                    S_VFRONT: if (vc_q == VC_LAST) begin
                        vc_d      = '0;
                        fb_addr_d = '0;
                        pend_d    = 1'b1;
                        state_d   = en ? S_VSYNC : S_IDLE;
                    end
                    default:  state_d = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        in_act        = (state_q == S_ACTIVE) && (hc_q < HC_ACT);
        vsync_d       = (state_q == S_VSYNC);
        href_d        = in_act;
        busy_d        = (state_q != S_IDLE);
        frame_done_d  = pend_q;
        d_d           = 8'h00;
        gb_d          = gb_q;
        if (in_act) begin
            if (!hc_q[0]) begin
                d_d  = {4'h0, fb_data[11:8]};
                gb_d = fb_data[7:0];
            end else begin
                d_d = gb_q;
            end
        end
        // Reads run two cycles ahead of byte 0, so a line's first read lands in the previous line period.
        next_line_act = ((state_q == S_VBACK) && (vc_q == VC_BACK_END)) ||
                        ((state_q == S_ACTIVE) && (vc_q != VC_ACT_END));
        fb_rd_d = ((state_q == S_ACTIVE) && !hc_q[0] && (hc_q < HC_RD_LIM)) ||
                  ((hc_q == HC_PRE) && next_line_act);
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hc_q         <= '0;
            vc_q         <= '0;
            fb_addr_q    <= '0;
            fb_rd_q      <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            d_q          <= 8'h00;
            gb_q         <= 8'h00;
            busy_q       <= 1'b0;
            pend_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hc_q         <= hc_d;
            vc_q         <= vc_d;
            fb_addr_q    <= fb_addr_d;
            fb_rd_q      <= fb_rd_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            d_q          <= d_d;
            gb_q         <= gb_d;
            busy_q       <= busy_d;
            pend_q       <= pend_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fb_addr    = fb_addr_q;
    assign fb_rd      = fb_rd_q;
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign d          = d_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_ov7670_emitter.sv
// Directed bench for ov7670_emitter on a 4x3 frame (LP=10, 60-cycle frame), RAM word n = 12'h100+n.
module tb_ov7670_emitter;
    logic        pclk = 1'b0;
    logic        rst_n, en;
    logic [18:0] fb_addr;
    logic        fb_rd;
    logic [11:0] fb_data;
    logic        vsync, href, busy, frame_done;
    logic [7:0]  d;

    int n_chk = 0;
    int n_err = 0;

    ov7670_emitter #(
        .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .en(en),
        .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
        .vsync(vsync), .href(href), .d(d),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (fb_rd) fb_data <= 12'h100 + fb_addr[11:0];
    end

    typedef struct {
        int          c;
        logic        vs;
        logic        hr;
        logic [7:0]  dd;
        logic        rd;
        logic [18:0] addr;
        logic        fd;
        logic        bz;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    function automatic vec_t mk(int c, logic vs, logic hr, logic [7:0] dd, logic rd,
                                logic [18:0] addr, logic fd, logic bz);
        vec_t v;
        v.c = c; v.vs = vs; v.hr = hr; v.dd = dd; v.rd = rd; v.addr = addr; v.fd = fd; v.bz = bz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge pclk);
    endtask

    task automatic wait_vsync();
        int k = 0;
        while (vsync !== 1'b1 && k < 30) begin
            step();
            k++;
        end
        chk("vsync_start", 32'(vsync), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int idx, rd_cnt, href_cnt, busy_cnt, bad;
        logic rd_h1, rd_h2;

        tbl[0]  = mk( 0, 1, 0, 8'h00, 0,  0, 0, 1);
        tbl[1]  = mk( 9, 1, 0, 8'h00, 0,  0, 0, 1);
        tbl[2]  = mk(10, 0, 0, 8'h00, 0,  0, 0, 1);
        tbl[3]  = mk(17, 0, 0, 8'h00, 0,  0, 0, 1);
        tbl[4]  = mk(18, 0, 0, 8'h00, 1,  0, 0, 1);
        tbl[5]  = mk(19, 0, 0, 8'h00, 0,  1, 0, 1);
        tbl[6]  = mk(20, 0, 1, 8'h01, 1,  1, 0, 1);
        tbl[7]  = mk(21, 0, 1, 8'h00, 0,  2, 0, 1);
        tbl[8]  = mk(22, 0, 1, 8'h01, 1,  2, 0, 1);
        tbl[9]  = mk(23, 0, 1, 8'h01, 0,  3, 0, 1);
        tbl[10] = mk(24, 0, 1, 8'h01, 1,  3, 0, 1);
        tbl[11] = mk(25, 0, 1, 8'h02, 0,  4, 0, 1);
        tbl[12] = mk(26, 0, 1, 8'h01, 0,  4, 0, 1);
        tbl[13] = mk(27, 0, 1, 8'h03, 0,  4, 0, 1);
        tbl[14] = mk(28, 0, 0, 8'h00, 1,  4, 0, 1);
        tbl[15] = mk(29, 0, 0, 8'h00, 0,  5, 0, 1);
        tbl[16] = mk(30, 0, 1, 8'h01, 1,  5, 0, 1);
        tbl[17] = mk(31, 0, 1, 8'h04, 0,  6, 0, 1);
        tbl[18] = mk(46, 0, 1, 8'h01, 0, 12, 0, 1);
        tbl[19] = mk(47, 0, 1, 8'h0B, 0, 12, 0, 1);
        tbl[20] = mk(48, 0, 0, 8'h00, 0, 12, 0, 1);
        tbl[21] = mk(58, 0, 0, 8'h00, 0, 12, 0, 1);
        tbl[22] = mk(59, 0, 0, 8'h00, 0,  0, 0, 1);
        tbl[23] = mk(60, 1, 0, 8'h00, 0,  0, 1, 1);
        tbl[24] = mk(61, 1, 0, 8'h00, 0,  0, 0, 1);
        tbl[25] = mk(78, 0, 0, 8'h00, 1,  0, 0, 1);
        tbl[26] = mk(80, 0, 1, 8'h01, 1,  1, 0, 1);
        tbl[27] = mk(81, 0, 1, 8'h00, 0,  2, 0, 1);

        // Reset state
        rst_n = 1'b0;
        en    = 1'b1;
        step();
        step();
        chk("rst_vsync", 32'(vsync), 0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_fb_rd", 32'(fb_rd), 0);

        // Tests 1 and 2: continuous frames, table plus per-cycle monitors
        do_reset();
        en = 1'b1;
        wait_vsync();
        idx = 0; rd_cnt = 0; href_cnt = 0; rd_h1 = 1'b0; rd_h2 = 1'b0;
        for (int c = 0; c <= 81; c++) begin
            if (idx < NV && tbl[idx].c == c) begin
                chk($sformatf("c%0d_vsync", c), 32'(vsync), 32'(tbl[idx].vs));
                chk($sformatf("c%0d_href", c),  32'(href),  32'(tbl[idx].hr));
                chk($sformatf("c%0d_d", c),     32'(d),     32'(tbl[idx].dd));
                chk($sformatf("c%0d_fb_rd", c), 32'(fb_rd), 32'(tbl[idx].rd));
                chk($sformatf("c%0d_addr", c),  32'(fb_addr), 32'(tbl[idx].addr));
                chk($sformatf("c%0d_done", c),  32'(frame_done), 32'(tbl[idx].fd));
                chk($sformatf("c%0d_busy", c),  32'(busy),  32'(tbl[idx].bz));
                idx++;
            end
            if (c < 60) begin
                if (fb_rd) begin
                    chk("rd_addr_seq", 32'(fb_addr), 32'(rd_cnt));
                    rd_cnt++;
                end
                if (rd_h2) chk("rd_to_byte0", {23'd0, href, d}, 32'h101);
                if (href) href_cnt++;
                rd_h2 = rd_h1;
                rd_h1 = fb_rd;
            end
            step();
        end
        chk("reads_per_frame", 32'(rd_cnt), 12);
        chk("href_cycles", 32'(href_cnt), 24);

        // Test 3: en dropped mid-frame
        do_reset();
        en = 1'b1;
        wait_vsync();
        busy_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (c == 25) en = 1'b0;
            if (busy) busy_cnt++;
            step();
        end
        chk("drop_busy_cycles", 32'(busy_cnt), 60);
        chk("drop_done", 32'(frame_done), 1);
        chk("drop_busy_after", 32'(busy), 0);
        chk("drop_vsync_after", 32'(vsync), 0);
        bad = 0;
        for (int c = 0; c < 110; c++) begin
            step();
            if (vsync || href || busy || fb_rd || frame_done) bad++;
        end
        chk("idle_quiet", 32'(bad), 0);

        // Test 4: reset mid-active-line, then restart
        en = 1'b1;
        wait_vsync();
        repeat (22) step();
        chk("pre_rst_href", 32'(href), 1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_outs", {frame_done, busy, fb_rd, vsync, href, d, 4'h0, fb_addr}, 0);
        step();
        chk("rst_over_en_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step();
        chk("start_latency_e", 32'(vsync), 0);
        step();
        chk("start_latency_e1", {30'd0, vsync, busy}, 32'h3);
        repeat (18) step();
        chk("restart_rd", 32'(fb_rd), 1);
        chk("restart_addr", 32'(fb_addr), 0);
        step();
        step();
        chk("restart_b0", 32'(d), 32'h01);
        step();
        chk("restart_b1", 32'(d), 32'h00);
        step();
        step();
        chk("restart_p1b1", 32'(d), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
